// File: rtl/pprm_inv_pipe.sv
`default_nettype none
// ============================================================================
// Module   : pprm_inv_pipe
// Purpose  : Multi-lane pipelined GF(2^8) inverter (AES field) with a
//            valid/ready handshake, bubble-collapsing register slices and a
//            sideband tag that travels with each beat.
//            Stage 1 : X -> A,B (nibbles of X^16), C (norm X^17 in GF(16))
//            Stage 2 : D = C^-1 in GF(16)
//            Stage 3 : Y = (A,B) * D = X^-1
//            REG_MASK[0] registers the stage 1->2 boundary, REG_MASK[1]
//            the stage 2->3 boundary; the output register always exists.
// Options  : define PPRM_INV_PIPE_AFFINE_EN to pass each lane through the
//            AES affine transform so out_data is the SubBytes value.
// Revision : 1.0 - initial release
// ============================================================================
module pprm_inv_pipe #(
  parameter int         LANES    = 4,
  parameter int         TAG_W    = 4,
  parameter logic [1:0] REG_MASK = 2'b11
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [8*LANES-1:0]   in_data,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [8*LANES-1:0]   out_data,
  output logic [TAG_W-1:0]     out_tag,
  output logic                 busy
);

  localparam int DW = 8 * LANES;
  localparam int MW = 12 * LANES;

  // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] sh;
    acc = 8'h00;
    sh  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = {sh[6:0], 1'b0} ^ (sh[7] ? 8'h1B : 8'h00);
    end
    return acc;
  endfunction

  function automatic logic [7:0] gf_sq(input logic [7:0] a);
    return gf_mul(a, a);
  endfunction

  // The GF(16) subfield of the AES field is spanned by {01, E1, 5C, 0C}
  // (E1 = 03^17).  Subfield values cross the slices as 4-bit coordinates in
  // that basis; these coordinates are recovered from bits 7,6,3,0.
  function automatic logic [3:0] sub_pack(input logic [7:0] s);
    return {s[3] ^ s[6] ^ s[7], s[6] ^ s[7], s[7], s[0] ^ s[7]};
  endfunction

  function automatic logic [7:0] sub_unpack(input logic [3:0] k);
    return ({8{k[0]}} & 8'h01) ^ ({8{k[1]}} & 8'hE1) ^
           ({8{k[2]}} & 8'h5C) ^ ({8{k[3]}} & 8'h0C);
  endfunction

  // X^16 goes forward as A,B; X^17 = X^16 * X is the subfield norm C
  function automatic logic [11:0] stage1(input logic [7:0] x);
    logic [7:0] x16;
    x16 = gf_sq(gf_sq(gf_sq(gf_sq(x))));
    return {x16, sub_pack(gf_mul(x16, x))};
  endfunction

  // D = C^14 = C^-1 inside GF(16); 0 maps to 0
  function automatic logic [11:0] stage2(input logic [11:0] abc);
    logic [7:0] c1;
    logic [7:0] c2;
    logic [7:0] c4;
    logic [7:0] c8;
    c1 = sub_unpack(abc[3:0]);
    c2 = gf_sq(c1);
    c4 = gf_sq(c2);
    c8 = gf_sq(c4);
    return {abc[11:4], sub_pack(gf_mul(gf_mul(c8, c4), c2))};
  endfunction

`ifdef PPRM_INV_PIPE_AFFINE_EN
  // AES affine transform: b ^ rotl1..rotl4 ^ 0x63
  function automatic logic [7:0] aes_affine(input logic [7:0] b);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^
           {b[3:0], b[7:4]} ^ 8'h63;
  endfunction
`endif

  // Y = X^16 * X^-17 = X^-1
  function automatic logic [7:0] stage3(input logic [11:0] abd);
    logic [7:0] y;
    y = gf_mul(abd[11:4], sub_unpack(abd[3:0]));
`ifdef PPRM_INV_PIPE_AFFINE_EN
    return aes_affine(y);
`else
    return y;
`endif
  endfunction

  // Boundary views: what each downstream stage sees, registered or not
  logic            ready0;
  logic            ready1;
  logic            ready2;
  logic            v0;
  logic            v1;
  logic [MW-1:0]   d0;
  logic [MW-1:0]   d1;
  logic [TAG_W-1:0] t0;
  logic [TAG_W-1:0] t1;
  logic            s0_busy;
  logic            s1_busy;
  logic [MW-1:0]   st1_out;
  logic [MW-1:0]   st2_out;
  logic [DW-1:0]   st3_out;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign st1_out[12*k +: 12] = stage1(in_data[8*k +: 8]);
    assign st2_out[12*k +: 12] = stage2(d0[12*k +: 12]);
    assign st3_out[8*k +: 8]   = stage3(d1[12*k +: 12]);
  end

  // Output stage accepts when empty or draining this cycle
  assign ready2   = !out_valid || out_ready;
  assign in_ready = ready0;

  if (REG_MASK[0]) begin : g_s0_reg
    logic             s0_valid;
    logic [MW-1:0]    s0_data;
    logic [TAG_W-1:0] s0_tag;

    // Stage 1->2 slice: loads whenever it can pass on or is empty
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s0_valid <= 1'b0;
        s0_data  <= '0;
        s0_tag   <= '0;
      end else if (ready0) begin
        s0_valid <= in_valid;
        if (in_valid) begin
          s0_data <= st1_out;
          s0_tag  <= in_tag;
        end
      end
    end

    assign ready0  = !s0_valid || ready1;
    assign v0      = s0_valid;
    assign d0      = s0_data;
    assign t0      = s0_tag;
    assign s0_busy = s0_valid;
  end else begin : g_s0_comb
    assign ready0  = ready1;
    assign v0      = in_valid;
    assign d0      = st1_out;
    assign t0      = in_tag;
    assign s0_busy = 1'b0;
  end

  if (REG_MASK[1]) begin : g_s1_reg
    logic             s1_valid;
    logic [MW-1:0]    s1_data;
    logic [TAG_W-1:0] s1_tag;

    // Stage 2->3 slice: same load rule, fed from the S0 view
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s1_valid <= 1'b0;
        s1_data  <= '0;
        s1_tag   <= '0;
      end else if (ready1) begin
        s1_valid <= v0;
        if (v0) begin
          s1_data <= st2_out;
          s1_tag  <= t0;
        end
      end
    end

    assign ready1  = !s1_valid || ready2;
    assign v1      = s1_valid;
    assign d1      = s1_data;
    assign t1      = s1_tag;
    assign s1_busy = s1_valid;
  end else begin : g_s1_comb
    assign ready1  = ready2;
    assign v1      = v0;
    assign d1      = st2_out;
    assign t1      = t0;
    assign s1_busy = 1'b0;
  end

  // Output register: holds data/tag stable while stalled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_tag   <= '0;
    end else if (ready2) begin
      out_valid <= v1;
      if (v1) begin
        out_data <= st3_out;
        out_tag  <= t1;
      end
    end
  end

  assign busy = s0_busy || s1_busy || out_valid;

endmodule
`default_nettype wire
